// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: FSM states, major
// opcodes and the ALU operand/operation select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecute  = 4'd2,
    StAluWb    = 4'd3,
    StMemAddr  = 4'd4,
    StMemRead  = 4'd5,
    StMemWb    = 4'd6,
    StMemWrite = 4'd7,
    StBranch   = 4'd8,
    StTrap     = 4'd9
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control word decoder (Moore outputs only). The fetch
// completion strobes depend on mem_ready and are formed by the caller using fetch_o.
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output logic       fetch_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       trap_o
);

  state_e state;
  assign state = state_e'(state_i);

  // Per-state control word; everything not named for a state stays 0.
  always_comb begin
    fetch_o         = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = SRC_A_PC;
    alu_src_b_o     = SRC_B_REG;
    alu_op_o        = ALU_OP_ADD;
    trap_o          = 1'b0;
    unique case (state)
      StFetch: begin
        fetch_o     = 1'b1;
        mem_read_o  = 1'b1;
        alu_src_a_o = SRC_A_PC;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_OP_ADD;
      end
      StDecode: begin
        // Branch target precomputed into ALUOut.
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      StExecute: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_REG;
        alu_op_o    = ALU_OP_FUNCT;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
      end
      StMemAddr: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_ADD;
      end
      StMemRead: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWrite: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o     = SRC_A_REG;
        alu_src_b_o     = SRC_B_REG;
        alu_op_o        = ALU_OP_SUB;
        pc_write_cond_o = 1'b1;
      end
      StTrap: begin
        trap_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multi-cycle RV32 core: holds the state register
// and next-state logic; the control word comes from ctrl_out_decode.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       trap
);

  state_e state_q, state_d;
  logic   fetch;

  // zero is ANDed with pc_write_cond outside this block.
  logic unused_zero;
  assign unused_zero = zero;

  // State register; reset aborts any instruction in flight and restarts fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: opcode is only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OP_RTYPE:           state_d = StExecute;
          OP_LOAD, OP_STORE:  state_d = StMemAddr;
          OP_BRANCH:          state_d = StBranch;
          default:            state_d = StTrap;
        endcase
      end
      StExecute: state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StMemAddr: begin
        // An opcode that changed to neither load nor store is treated as illegal.
        case (opcode)
          OP_LOAD:  state_d = StMemRead;
          OP_STORE: state_d = StMemWrite;
          default:  state_d = StTrap;
        endcase
      end
      StMemRead: begin
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: state_d = StFetch;
      StMemWrite: begin
        if (mem_ready) state_d = StFetch;
      end
      StBranch: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  ctrl_out_decode u_ctrl_out_decode (
    .state_i         (state_q),
    .fetch_o         (fetch),
    .pc_write_cond_o (pc_write_cond),
    .iord_o          (iord),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .trap_o          (trap)
  );

  // Fetch completion strobes: the only outputs that depend on an input.
  always_comb begin
    ir_write = fetch & mem_ready;
    pc_write = fetch & mem_ready;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle control words from the opcode and the chosen wait counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .trap          (trap)
  );

  // Observed word: pcw pcc iord mr mw irw m2r rw a[2] b[2] op[2] trap
  logic [14:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, trap};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [14:0] cw(input logic pcw, input logic pcc, input logic ia,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic tr);
    return {pcw, pcc, ia, mr, mw, irw, m2r, rw, a, b, op, tr};
  endfunction

  logic [14:0] w_fwait, w_fdone, w_dec, w_exe, w_awb, w_maddr, w_mrd, w_mwb, w_mwr, w_br, w_trp;

  logic [14:0] exp_q[$];
  logic        rdy_q[$];
  logic [6:0]  opc_q[$];

  task automatic push(input logic [14:0] e, input logic r, input logic [6:0] o);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    opc_q.push_back(o);
  endtask

  // Cycle where mem_ready and opcode must not matter: drive them randomly.
  task automatic push_free(input logic [14:0] e);
    push(e, 1'($urandom), 7'($urandom));
  endtask

  // Expand one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(w_fwait, 1'b0, 7'($urandom));
    push(w_fdone, 1'b1, 7'($urandom));
    push(w_dec, 1'($urandom), op);
    case (op)
      7'b0110011: begin
        push_free(w_exe);
        push_free(w_awb);
      end
      7'b0000011: begin
        push(w_maddr, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(w_mrd, 1'b0, 7'($urandom));
        push(w_mrd, 1'b1, 7'($urandom));
        push_free(w_mwb);
      end
      7'b0100011: begin
        push(w_maddr, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(w_mwr, 1'b0, 7'($urandom));
        push(w_mwr, 1'b1, 7'($urandom));
      end
      7'b1100011: push_free(w_br);
      default:    push_free(w_trp);
    endcase
  endtask

  // Play n queued cycles: drive at negedge, compare 2 time units later.
  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode    = opc_q.pop_front();
      zero      = 1'($urandom);
      #2;
      check_eq($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run_all(input string tag);
    run(exp_q.size(), tag);
  endtask

  // Asynchronous reset between cycles, held across one rising edge.
  task automatic do_reset(input string tag);
    exp_q.delete();
    rdy_q.delete();
    opc_q.delete();
    #1;
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_eq({tag, "_async"}, 32'(obs), 32'(w_fwait));
    @(negedge clk);
    #2;
    check_eq({tag, "_hold"}, 32'(obs), 32'(w_fwait));
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal [4];
    legal[0] = 7'b0110011;
    legal[1] = 7'b0000011;
    legal[2] = 7'b0100011;
    legal[3] = 7'b1100011;

    w_fwait = cw(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0);
    w_fdone = cw(1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 0);
    w_dec   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0);
    w_exe   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 0);
    w_awb   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    w_maddr = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0);
    w_mrd   = cw(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_mwb   = cw(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0);
    w_mwr   = cw(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    w_br    = cw(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0);
    w_trp   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    #1;
    check_eq("reset_state", 32'(obs), 32'(w_fwait));
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;

    // R-type, zero-wait memory.
    build(7'b0110011, 0, 0);
    run_all("rtype");

    // Reset asserted in EXECUTE: no ALU_WB may follow.
    build(7'b0110011, 0, 0);
    run(3, "rst_pre");
    do_reset("rst_exec");
    build(7'b0110011, 0, 0);
    run_all("after_rst");

    // LW with two wait cycles in MEM_READ.
    build(7'b0000011, 0, 2);
    run_all("lw_wait2");

    // SW then BEQ.
    build(7'b0100011, 0, 0);
    build(7'b1100011, 0, 0);
    run_all("sw_beq");

    // Five-cycle fetch stall.
    build(7'b0110011, 5, 0);
    run_all("fetch_stall");

    // Randomized legal instruction stream.
    for (int i = 0; i < 40; i++) begin
      build(legal[$urandom_range(0, 3)], int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end
    run_all("rand");

    // Illegal opcode parks in TRAP until reset.
    build(7'b1111111, 1, 0);
    for (int i = 0; i < 20; i++) push_free(w_trp);
    run_all("trap");
    do_reset("rst_trap");
    build(7'b0000011, 1, 1);
    run_all("post_trap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multi-cycle RV32 core. Decodes the 7-bit major opcode from the instruction register, steps the shared ALU, register file and unified memory through fetch/decode/execute/memory/writeback, and drives the 2-bit `alu_op` consumed by the ALU control unit. Supports R-type, load (LW), store (SW) and BEQ. Any other opcode parks the core in a trap state.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag; sampled only in BRANCH.
- `mem_ready`  in  1  memory handshake; access completes in the cycle it is high.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by `zero` (external AND).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = A register, 10 = OldPC.
- `alu_src_b`  out  2  00 = B register, 01 = constant 4, 10 = immediate.
- `alu_op`  out  2  00 = add, 01 = subtract/compare, 10 = use funct fields.
- `trap`  out  1  high while in TRAP.

## Operation
- Moore machine: every output is a pure function of the current state. Unlisted outputs are 0.
- FETCH: `iord`=0, `mem_read`=1, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00. While `mem_ready`=0, hold FETCH with no `ir_write`/`pc_write`. When `mem_ready`=1, assert `ir_write`=1 and `pc_write`=1 (PC+4), then go to DECODE.
- DECODE: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXECUTE
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - else → TRAP
- EXECUTE: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10 → ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0 → FETCH.
- MEM_ADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00 → MEM_READ if load, MEM_WRITE if store.
- MEM_READ: `iord`=1, `mem_read`=1. Hold until `mem_ready`, then → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1 → FETCH.
- MEM_WRITE: `iord`=1, `mem_write`=1. Hold until `mem_ready`, then → FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1 → FETCH.
- TRAP: `trap`=1, all enables 0. Absorbing state; only reset exits.
- FETCH completion outputs (`ir_write`, `pc_write`) are the only Mealy terms; they are gated by `mem_ready`.

## Timing
- Reset: asynchronous assertion forces FETCH immediately. With `mem_ready`=0 the outputs are then `mem_read`=1, `alu_src_b`=01, and everything else 0.
- Reset mid-instruction aborts it. No partial writeback may follow.
- Cycle counts with zero-wait memory:
  - R-type: 4 (FETCH, DECODE, EXECUTE, ALU_WB)
  - LW: 5
  - SW: 4
  - BEQ: 3
- Each wait cycle adds exactly 1.
- `mem_read`/`mem_write` stay asserted, and the address select stays stable, for every wait cycle.
- `mem_read` and `mem_write` are never high together.
- `reg_write` and `pc_write` are never high together.
- `opcode` is sampled only in DECODE and MEM_ADDR; changes at any other time are ignored.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum (4-bit encoding)
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH
  - ALU_OP_ADD/SUB/FUNCT
  - the SRC_A_* / SRC_B_* encodings
- One natural sub-module: `ctrl_out_decode`, a combinational state → control-word decoder. The top keeps the state register and next-state logic.

## Test plan
- Reset: hold `reset_n`=0 mid-EXECUTE, release → state FETCH, `reg_write`=0, `mem_read`=1, `alu_op`=00.
- R-type, `mem_ready`=1: opcode 0110011 → `alu_op`=10 in cycle 3, `reg_write`=1 in cycle 4, FETCH in cycle 5.
- LW with 2 wait cycles in MEM_READ: opcode 0000011 → `mem_read`=1 and `iord`=1 for 3 cycles, then `reg_write`=1 with `mem_to_reg`=1. Total 7 cycles.
- SW then BEQ: opcode 0100011 → one cycle with `mem_write`=1, `iord`=1. Then opcode 1100011 with `zero`=1 → `pc_write_cond`=1, `alu_op`=01 in cycle 3.
- Illegal opcode 1111111 → TRAP after DECODE. `trap`=1 and all enables 0 for 20 cycles. Reset returns to FETCH.
- Fetch stall of 5 cycles: `ir_write`/`pc_write` stay 0 until the `mem_ready` cycle, then each pulses for exactly 1 cycle.
